// File: rtl/ms_tip_pkg.sv
// ---------------------------------------------------------------------------
// ms_tip_pkg
// Shared constants for the memory-subsystem read path. Every block on the
// read-data side of the lane controller pulls its lane width, default FIFO
// depth and lane count from here, so that they always agree.
//
// Contents:
//   LANE_DATA_WIDTH      bits per DQS lane per SCLK beat (8 DQ x 8 beats)
//   DEFAULT_FIFO_DEPTH   default read-FIFO depth per lane
//   DEFAULT_MIN_ENTRIES  default occupancy threshold for entries_in_fifo
//   IOG_DQS_LANES        number of DQS lanes feeding the controller
//   maxCount()           helper returning the larger of two occupancy counts
// ---------------------------------------------------------------------------
package ms_tip_pkg;

    localparam int LANE_DATA_WIDTH     = 64;
    localparam int DEFAULT_FIFO_DEPTH  = 8;
    localparam int DEFAULT_MIN_ENTRIES = 1;
    localparam int IOG_DQS_LANES       = 4;

    // Larger of two unsigned occupancy values; used by the high-water tracker.
    function automatic logic [7:0] maxCount(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage : ms_tip_pkg

// File: rtl/lane_rd_fifo_mem.sv
// ---------------------------------------------------------------------------
// lane_rd_fifo_mem
// DEPTH x DATA_WIDTH storage for one lane's read FIFO. Writes are
// synchronous; reads are registered, so data appears one SCLK after rd_en_i.
// The array itself has no reset, so it can map onto LSRAM/uSRAM. Only the
// output register is reset, because downstream logic sees it directly.
//
// Ports:
//   SCLK       in   fabric clock
//   reset_n    in   asynchronous, active-low reset (output register only)
//   wr_en_i    in   write strobe
//   wr_addr_i  in   write address
//   wr_data_i  in   write data
//   rd_en_i    in   read strobe; loads rd_data_o from rd_addr_i
//   rd_addr_i  in   read address
//   rd_data_o  out  registered read data; holds when rd_en_i is low
// ---------------------------------------------------------------------------
module lane_rd_fifo_mem
    import ms_tip_pkg::*;
#(
    parameter int DATA_WIDTH = LANE_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_FIFO_DEPTH,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  SCLK,
    input  logic                  reset_n,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Storage array: plain synchronous write, no reset so it stays a RAM.
    always_ff @(posedge SCLK) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read port. A read and a write to the same address in one
    // cycle returns the old contents, which is what a full FIFO doing a
    // simultaneous push and pop needs.
    always_ff @(posedge SCLK or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : lane_rd_fifo_mem

// File: rtl/lane_rd_fifo.sv
// ---------------------------------------------------------------------------
// lane_rd_fifo
// Per-DQS-lane read-data FIFO in the SCLK domain, directly upstream of the
// lane controller. It captures IOG read beats and raises entries_in_fifo once
// enough beats are buffered. The controller ANDs that bit across all lanes
// and pops every lane together with read_fifo_en. Popped data appears on
// rd_data one SCLK after the pop, in line with dfi_rddata_valid.
//
// Configuration macro:
//   LANE_RD_FIFO_HWM_EN  adds the hwm output, which holds the peak occupancy
//                        since reset or flush.
//
// Ports:
//   SCLK             in   fabric clock
//   reset_n          in   asynchronous, active-low reset
//   flush            in   synchronous clear of pointers, count and errors
//   iog_rd_valid     in   write strobe, one beat from the IOG lane
//   iog_rd_data      in   beat data
//   read_fifo_en     in   pop strobe from the lane controller
//   entries_in_fifo  out  occupancy >= MIN_ENTRIES (registered)
//   rd_data          out  registered popped beat
//   full             out  occupancy == DEPTH (registered)
//   overflow_err     out  sticky: write while full with no pop
//   underflow_err    out  sticky: pop while empty
//   hwm              out  peak occupancy (LANE_RD_FIFO_HWM_EN only)
// ---------------------------------------------------------------------------
module lane_rd_fifo
    import ms_tip_pkg::*;
#(
    parameter int DATA_WIDTH  = LANE_DATA_WIDTH,
    parameter int DEPTH       = DEFAULT_FIFO_DEPTH,
    parameter int MIN_ENTRIES = DEFAULT_MIN_ENTRIES,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  SCLK,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  iog_rd_valid,
    input  logic [DATA_WIDTH-1:0] iog_rd_data,
    input  logic                  read_fifo_en,
`ifdef LANE_RD_FIFO_HWM_EN
    output logic [ADDR_W:0]       hwm,
`endif
    output logic                  entries_in_fifo,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  overflow_err,
    output logic                  underflow_err
);

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   MIN_COUNT  = (ADDR_W+1)'(MIN_ENTRIES);
    localparam logic [ADDR_W-1:0] PTR_ONE    = 1;
    localparam logic [ADDR_W:0]   CNT_ONE    = 1;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              entries_q, entries_d;
    logic              full_q, full_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              pop_ok;
    logic              wr_accept;
    logic              mem_wr_en;
    logic              mem_rd_en;

    // A pop needs data already present, so a write into an empty FIFO never
    // falls through in the same cycle. A write to a full FIFO is accepted
    // only when a pop frees the slot in that same cycle.
    assign pop_ok    = read_fifo_en && (count_q != '0);
    assign wr_accept = iog_rd_valid && (!full_q || pop_ok);
    assign mem_wr_en = wr_accept && !flush;
    assign mem_rd_en = pop_ok && !flush;

    // Next-state for pointers, occupancy and sticky errors. Flush wins over
    // any write or pop in the same cycle and raises no error. The status
    // flags are computed from the next count so that they are registered but
    // still line up with the count.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (wr_accept && !pop_ok) begin
                count_d = count_q + CNT_ONE;
            end else if (pop_ok && !wr_accept) begin
                count_d = count_q - CNT_ONE;
            end
            if (iog_rd_valid && !wr_accept) begin
                overflow_d = 1'b1;
            end
            if (read_fifo_en && (count_q == '0)) begin
                underflow_d = 1'b1;
            end
        end
        entries_d = (count_d >= MIN_COUNT);
        full_d    = (count_d == FULL_COUNT);
    end

    // Control-state registers.
    always_ff @(posedge SCLK or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            entries_q   <= 1'b0;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            entries_q   <= entries_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef LANE_RD_FIFO_HWM_EN
    logic [ADDR_W:0] hwm_q, hwm_d;

    // Peak occupancy tracks the next count, so it moves on the same edge as
    // the count itself.
    always_comb begin
        hwm_d = hwm_q;
        if (flush) begin
            hwm_d = '0;
        end else begin
            hwm_d = (ADDR_W+1)'(maxCount(8'(count_d), 8'(hwm_q)));
        end
    end

    always_ff @(posedge SCLK or negedge reset_n) begin
        if (!reset_n) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm = hwm_q;
`endif

    lane_rd_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .SCLK      (SCLK),
        .reset_n   (reset_n),
        .wr_en_i   (mem_wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (iog_rd_data),
        .rd_en_i   (mem_rd_en),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data)
    );

    assign entries_in_fifo = entries_q;
    assign full            = full_q;
    assign overflow_err    = overflow_q;
    assign underflow_err   = underflow_q;

endmodule : lane_rd_fifo

// File: tb/tb_lane_rd_fifo.sv
// ---------------------------------------------------------------------------
// tb_lane_rd_fifo
// Self-checking bench for lane_rd_fifo with default parameters (64-bit data,
// depth 8, threshold 1). A behavioural queue model decides the outcome of
// each cycle. Expected popped beats go into a scoreboard, and an independent
// monitor compares them against rd_data. The status outputs are compared
// after every cycle.
// ---------------------------------------------------------------------------
module tb_lane_rd_fifo;

    localparam int DW    = 64;
    localparam int DEPTH = 8;

    logic          SCLK;
    logic          reset_n;
    logic          flush;
    logic          iog_rd_valid;
    logic [DW-1:0] iog_rd_data;
    logic          read_fifo_en;
    logic          entries_in_fifo;
    logic [DW-1:0] rd_data;
    logic          full;
    logic          overflow_err;
    logic          underflow_err;
`ifdef LANE_RD_FIFO_HWM_EN
    logic [3:0]    hwm;
`endif

    lane_rd_fifo dut (
        .SCLK            (SCLK),
        .reset_n         (reset_n),
        .flush           (flush),
        .iog_rd_valid    (iog_rd_valid),
        .iog_rd_data     (iog_rd_data),
        .read_fifo_en    (read_fifo_en),
`ifdef LANE_RD_FIFO_HWM_EN
        .hwm             (hwm),
`endif
        .entries_in_fifo (entries_in_fifo),
        .rd_data         (rd_data),
        .full            (full),
        .overflow_err    (overflow_err),
        .underflow_err   (underflow_err)
    );

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } expBeat_t;

    logic [DW-1:0] modelQ [$];
    expBeat_t      expQ [$];
    logic [DW-1:0] expRd;
    bit            modelOvf;
    bit            modelUnf;
    int            modelHwm;
    int            edgeCount;
    int            checks;
    int            passes;

    // Free-running SCLK.
    initial begin
        SCLK = 1'b0;
        forever #5 SCLK = ~SCLK;
    end

    // Counts active edges so that scoreboard entries know when they are due.
    always @(posedge SCLK) edgeCount <= edgeCount + 1;

    // Records one comparison and reports it if it does not match.
    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drives one cycle. The model decides the outcome from the current
    // occupancy, then the status outputs are compared after the edge.
    task automatic applyStimulus(input bit v, input logic [DW-1:0] d,
                                 input bit p, input bit f);
        int  cnt;
        bit  popOk;
        bit  wrOk;
        cnt          = modelQ.size();
        iog_rd_valid = v;
        iog_rd_data  = d;
        read_fifo_en = p;
        flush        = f;
        if (f) begin
            modelQ.delete();
            modelOvf = 0;
            modelUnf = 0;
            modelHwm = 0;
        end else begin
            popOk = p && (cnt != 0);
            wrOk  = v && ((cnt < DEPTH) || popOk);
            if (popOk) begin
                expBeat_t e;
                e.due  = edgeCount + 1;
                e.data = modelQ.pop_front();
                expQ.push_back(e);
            end
            if (wrOk) modelQ.push_back(d);
            if (p && cnt == 0) modelUnf = 1;
            if (v && !wrOk) modelOvf = 1;
            if (modelQ.size() > modelHwm) modelHwm = modelQ.size();
        end
        @(posedge SCLK);
        #1;
        iog_rd_valid = 1'b0;
        read_fifo_en = 1'b0;
        flush        = 1'b0;
        checkOutput("entries_in_fifo", DW'(entries_in_fifo), DW'(modelQ.size() >= 1));
        checkOutput("full", DW'(full), DW'(modelQ.size() == DEPTH));
        checkOutput("overflow_err", DW'(overflow_err), DW'(modelOvf));
        checkOutput("underflow_err", DW'(underflow_err), DW'(modelUnf));
`ifdef LANE_RD_FIFO_HWM_EN
        checkOutput("hwm", DW'(hwm), DW'(modelHwm));
`endif
    endtask

    // Asserts reset partway through a cycle and checks that every output has
    // cleared before the next clock edge.
    task automatic applyReset();
        #2;
        reset_n = 1'b0;
        #1;
        modelQ.delete();
        expQ.delete();
        expRd    = '0;
        modelOvf = 0;
        modelUnf = 0;
        modelHwm = 0;
        checkOutput("reset entries_in_fifo", DW'(entries_in_fifo), '0);
        checkOutput("reset full", DW'(full), '0);
        checkOutput("reset rd_data", rd_data, '0);
        checkOutput("reset overflow_err", DW'(overflow_err), '0);
        checkOutput("reset underflow_err", DW'(underflow_err), '0);
`ifdef LANE_RD_FIFO_HWM_EN
        checkOutput("reset hwm", DW'(hwm), '0);
`endif
        @(negedge SCLK);
        reset_n = 1'b1;
    endtask

    // Monitor: once a scoreboard entry is due, it becomes the expected
    // rd_data. rd_data must hold that value from then on, which also checks
    // that it holds between pops.
    initial begin
        forever begin
            @(negedge SCLK);
            while (expQ.size() > 0 && expQ[0].due <= edgeCount) begin
                expBeat_t e;
                e     = expQ.pop_front();
                expRd = e.data;
            end
            if (reset_n) checkOutput("rd_data", rd_data, expRd);
        end
    end

    initial begin
        checks       = 0;
        passes       = 0;
        edgeCount    = 0;
        expRd        = '0;
        modelOvf     = 0;
        modelUnf     = 0;
        modelHwm     = 0;
        reset_n      = 1'b0;
        flush        = 1'b0;
        iog_rd_valid = 1'b0;
        iog_rd_data  = '0;
        read_fifo_en = 1'b0;
        #1;
        checkOutput("por entries_in_fifo", DW'(entries_in_fifo), '0);
        checkOutput("por rd_data", rd_data, '0);
        checkOutput("por full", DW'(full), '0);
        @(negedge SCLK);
        @(negedge SCLK);
        reset_n = 1'b1;

        $display("[TB] three writes then three pops");
        applyStimulus(1, 64'hA1, 0, 0);
        applyStimulus(1, 64'hA2, 0, 0);
        applyStimulus(1, 64'hA3, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, '0, 1, 0);
        applyStimulus(0, '0, 0, 0);

        $display("[TB] fill to depth and overflow");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 64'hB0 + DW'(i), 0, 0);
        applyStimulus(1, 64'hDEAD, 0, 0);
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(0, '0, 1, 0);
        applyStimulus(0, '0, 0, 1);

        $display("[TB] write and pop together while full");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 64'hC0 + DW'(i), 0, 0);
        applyStimulus(1, 64'hCF, 1, 0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, '0, 1, 0);
        applyStimulus(0, '0, 0, 1);

        $display("[TB] pop on empty with simultaneous write");
        applyStimulus(1, 64'h55, 1, 0);
        applyStimulus(0, '0, 0, 0);
        applyStimulus(0, '0, 1, 0);
        applyStimulus(0, '0, 0, 1);

        $display("[TB] interleaved traffic across pointer wrap");
        for (int i = 0; i < 20; i++) applyStimulus(1, 64'hD00 + DW'(i), (i >= 2), 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, '0, 1, 0);
        applyStimulus(0, '0, 0, 1);

        $display("[TB] reset in the middle of a burst");
        for (int i = 0; i < 5; i++) applyStimulus(1, 64'hE0 + DW'(i), 0, 0);
        applyReset();
        applyStimulus(1, 64'hF1, 0, 0);
        applyStimulus(0, '0, 1, 0);
        applyStimulus(0, '0, 0, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom % 3) != 0, {$urandom, $urandom},
                          ($urandom % 2) == 1, ($urandom % 50) == 0);
        end
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, '0, 1, 0);
        applyStimulus(0, '0, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_lane_rd_fifo
